cnt_ctrl: RTL

Programmable counter controller. It sequences a single up-counter of parameterisable width through configure, arm, run, pause and done phases. A prescaler divides the clock before each count step. Sits between a host-side config/command interface and any logic that consumes count ticks, terminal-count events or wrap events.

---
 rtl/cnt_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cnt_ctrl.sv
// Programmable counter controller: config handshake, prescaled up-counter, one-shot/wrap modes.
// Optional wrap event counter output enabled by defining CNT_CTRL_WRAP_CNT_EN.
module cnt_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_wrap,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic               busy,
  output logic [WIDTH-1:0]   cnt,
  output logic               tick,
  output logic               wrap_pulse,
  output logic               done
`ifdef CNT_CTRL_WRAP_CNT_EN
  ,
  output logic [15:0]        wrap_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]   limit_q;
  logic               wrap_q;
  logic [PRESC_W-1:0] presc_q;

  logic xfer;
  logic do_clear;

  // cfg_ready is registered and only high in IDLE/ARMED/DONE, so a transfer
  // can never happen while the counter is active.
  assign xfer     = cfg_valid && cfg_ready;
  assign do_clear = clear && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      presc_cnt  <= '0;
      limit_q    <= '0;
      wrap_q     <= 1'b0;
      presc_q    <= '0;
      tick       <= 1'b0;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
`ifdef CNT_CTRL_WRAP_CNT_EN
      wrap_cnt   <= '0;
`endif
    end else begin
      tick       <= 1'b0;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;

      if (xfer) begin
        limit_q   <= cfg_limit;
        wrap_q    <= cfg_wrap;
        presc_q   <= cfg_presc;
        cnt       <= '0;
        presc_cnt <= '0;
        state     <= ARMED;
        busy      <= 1'b0;
        cfg_ready <= 1'b1;
`ifdef CNT_CTRL_WRAP_CNT_EN
        wrap_cnt  <= '0;
`endif
      end else if (do_clear) begin
        cnt       <= '0;
        presc_cnt <= '0;
        state     <= ARMED;
        busy      <= 1'b0;
        cfg_ready <= 1'b1;
`ifdef CNT_CTRL_WRAP_CNT_EN
        wrap_cnt  <= '0;
`endif
      end else begin
        unique case (state)
          ARMED: begin
            if (start) begin
              cnt       <= '0;
              presc_cnt <= '0;
              state     <= RUN;
              busy      <= 1'b1;
              cfg_ready <= 1'b0;
            end
          end
          RUN: begin
            if (stop) begin
              state <= PAUSE;
            end else if (presc_cnt == presc_q) begin
              presc_cnt <= '0;
              if (cnt != limit_q) begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b1;
              end else if (wrap_q) begin
                cnt        <= '0;
                tick       <= 1'b1;
                wrap_pulse <= 1'b1;
`ifdef CNT_CTRL_WRAP_CNT_EN
                if (wrap_cnt != 16'hFFFF) wrap_cnt <= wrap_cnt + 16'd1;
`endif
              end else begin
                done      <= 1'b1;
                state     <= DONE;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
              end
            end else begin
              presc_cnt <= presc_cnt + 1'b1;
            end
          end
          PAUSE: begin
            if (start) state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
